bios_failover_ctrl: RTL and testbench

- Parametrised successor to the dual-socket BIOS chip-select logic, built for N BIOS devices.
- Latches the requested next BIOS while platform PCI reset is asserted. Drives a one-cold chip-select for the active device.
- Adds a boot watchdog: if POST-complete is not seen within a timeout after reset release, it advances to the next BIOS and requests a platform reset, up to a retry limit, then flags failure.
- Sits in the top-level control hierarchy beside the power sequencer, which consumes Rst_Req.

---
 rtl/bios_failover_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_bios_failover_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_failover_ctrl.sv
// BIOS chip-select and boot-failover controller for NUM_BIOS devices.
// The next BIOS is latched while PCI reset is held. A boot watchdog advances
// to the next device and asks the power sequencer for a platform reset when
// POST does not complete in time. After MAX_RETRY failovers it flags failure.
module bios_failover_ctrl #(
    parameter int unsigned NUM_BIOS     = 2,
    parameter int unsigned SEL_W        = 1,
    parameter logic [15:0] BOOT_TIMEOUT = 16'd600,
    parameter int unsigned TMR_W        = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RST_PULSE    = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                PciRstN,
    input  logic                Pwr_ok,
    input  logic                Post_Done,
    input  logic                Tick,
    input  logic [SEL_W-1:0]    Next_Bios,
    output logic [SEL_W-1:0]    Active_Bios,
    output logic [SEL_W-1:0]    Next_Bios_latch,
    output logic [NUM_BIOS-1:0] BIOS_CS_N,
    output logic                Boot_Ok,
    output logic                Bios_Fail,
    output logic                Rst_Req,
    output logic [2:0]          Retry_Cnt
);

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_IN_RST   = 3'd1;
    localparam logic [2:0] ST_BOOTING  = 3'd2;
    localparam logic [2:0] ST_REQ      = 3'd3;
    localparam logic [2:0] ST_WAIT_RST = 3'd4;
    localparam logic [2:0] ST_BOOTED   = 3'd5;
    localparam logic [2:0] ST_FAILED   = 3'd6;

    localparam logic [TMR_W-1:0] TMO        = TMR_W'(BOOT_TIMEOUT);
    localparam logic [7:0]       PULSE_LAST = 8'(RST_PULSE - 1);
    localparam logic [SEL_W-1:0] LAST_BIOS  = SEL_W'(NUM_BIOS - 1);

    logic [1:0]          pcirst_sync, pwr_sync, post_sync;
    logic                pcirst_s, pwr_s, post_s;
    logic [2:0]          state, state_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic [7:0]          pulse_cnt, pulse_nx;
    logic                fo_pending, fo_nx;
    logic [SEL_W-1:0]    active_nx, latch_nx, next_clamped, active_inc;
    logic [2:0]          retry_nx;
    logic                boot_ok_nx, fail_nx, rst_req_nx;
    logic [NUM_BIOS-1:0] cs_nx;

    assign pcirst_s = pcirst_sync[1];
    assign pwr_s    = pwr_sync[1];
    assign post_s   = post_sync[1];

    assign next_clamped = (32'(Next_Bios) < NUM_BIOS) ? Next_Bios : '0;
    assign active_inc   = (Active_Bios == LAST_BIOS) ? '0 : Active_Bios + SEL_W'(1);

    // Two-flop synchronisers for the asynchronous platform inputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pcirst_sync <= '0;
            pwr_sync    <= '0;
            post_sync   <= '0;
        end else begin
            pcirst_sync <= {pcirst_sync[0], PciRstN};
            pwr_sync    <= {pwr_sync[0], Pwr_ok};
            post_sync   <= {post_sync[0], Post_Done};
        end
    end

    // Next-state and next-output logic; power loss overrides every state
    always_comb begin
        state_nx   = state;
        active_nx  = Active_Bios;
        latch_nx   = Next_Bios_latch;
        retry_nx   = Retry_Cnt;
        boot_ok_nx = Boot_Ok;
        fail_nx    = Bios_Fail;
        rst_req_nx = Rst_Req;
        timer_nx   = timer;
        fo_nx      = fo_pending;
        pulse_nx   = pulse_cnt;
        if (!pwr_s) begin
            state_nx   = ST_OFF;
            active_nx  = '0;
            latch_nx   = '0;
            retry_nx   = '0;
            boot_ok_nx = 1'b0;
            fail_nx    = 1'b0;
            rst_req_nx = 1'b0;
            timer_nx   = '0;
            fo_nx      = 1'b0;
            pulse_nx   = '0;
        end else begin
            case (state)
                ST_OFF: state_nx = ST_IN_RST;
                // Exits only when PciRstN is seen high; entry is always with
                // PciRstN low or from OFF, so a level test acts as the rising edge.
                ST_IN_RST: begin
                    if (!pcirst_s) begin
                        if (!fo_pending) latch_nx = next_clamped;
                    end else begin
                        active_nx = Next_Bios_latch;
                        timer_nx  = '0;
                        fo_nx     = 1'b0;
                        state_nx  = ST_BOOTING;
                    end
                end
                ST_BOOTING: begin
                    if (Tick && (timer != '1)) timer_nx = timer + TMR_W'(1);
                    if (post_s) begin
                        state_nx   = ST_BOOTED;
                        boot_ok_nx = 1'b1;
                    end else if (timer == TMO) begin
                        if (32'(Retry_Cnt) < MAX_RETRY) begin
                            retry_nx   = Retry_Cnt + 3'd1;
                            latch_nx   = active_inc;
                            fo_nx      = 1'b1;
                            rst_req_nx = 1'b1;
                            pulse_nx   = '0;
                            state_nx   = ST_REQ;
                        end else begin
                            fail_nx  = 1'b1;
                            state_nx = ST_FAILED;
                        end
                    end else if (!pcirst_s) begin
                        state_nx = ST_IN_RST;
                    end
                end
                ST_REQ: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        rst_req_nx = 1'b0;
                        state_nx   = ST_WAIT_RST;
                    end else begin
                        pulse_nx = pulse_cnt + 8'd1;
                    end
                end
                ST_WAIT_RST: if (!pcirst_s) state_nx = ST_IN_RST;
                ST_BOOTED: begin
                    if (!pcirst_s) begin
                        boot_ok_nx = 1'b0;
                        retry_nx   = '0;
                        state_nx   = ST_IN_RST;
                    end
                end
                ST_FAILED: rst_req_nx = 1'b0;
                default:   state_nx = ST_OFF;
            endcase
        end
    end

    // One-cold select derived from the next state so it lands with Active_Bios
    always_comb begin
        cs_nx = '1;
        if (state_nx != ST_OFF) begin
            for (int unsigned i = 0; i < NUM_BIOS; i++) begin
                if (active_nx == SEL_W'(i)) cs_nx[i] = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= ST_OFF;
            Active_Bios     <= '0;
            Next_Bios_latch <= '0;
            Retry_Cnt       <= '0;
            Boot_Ok         <= 1'b0;
            Bios_Fail       <= 1'b0;
            Rst_Req         <= 1'b0;
            BIOS_CS_N       <= '1;
            timer           <= '0;
            fo_pending      <= 1'b0;
            pulse_cnt       <= '0;
        end else begin
            state           <= state_nx;
            Active_Bios     <= active_nx;
            Next_Bios_latch <= latch_nx;
            Retry_Cnt       <= retry_nx;
            Boot_Ok         <= boot_ok_nx;
            Bios_Fail       <= fail_nx;
            Rst_Req         <= rst_req_nx;
            BIOS_CS_N       <= cs_nx;
            timer           <= timer_nx;
            fo_pending      <= fo_nx;
            pulse_cnt       <= pulse_nx;
        end
    end

endmodule

// File: tb/tb_bios_failover_ctrl.sv
// Testbench for bios_failover_ctrl: a 2-socket instance for the main
// scenarios and a 3-socket instance for clamping and wrap-around.
module tb_bios_failover_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset, PciRstN, Pwr_ok, Post_Done, Tick;
    logic [0:0] Next_Bios;
    logic [1:0] next3;

    logic [0:0] Active_Bios, Next_Bios_latch;
    logic [1:0] BIOS_CS_N;
    logic       Boot_Ok, Bios_Fail, Rst_Req;
    logic [2:0] Retry_Cnt;

    logic [1:0] active3, latch3;
    logic [2:0] cs3;
    logic       boot_ok3, fail3, rst_req3;
    logic [2:0] retry3;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // reference model state
    int m_active;
    int m_retry;
    int m_latch;

    bios_failover_ctrl #(
        .NUM_BIOS(2), .SEL_W(1), .BOOT_TIMEOUT(16'd8), .TMR_W(16),
        .MAX_RETRY(2), .RST_PULSE(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .PciRstN(PciRstN), .Pwr_ok(Pwr_ok),
        .Post_Done(Post_Done), .Tick(Tick), .Next_Bios(Next_Bios),
        .Active_Bios(Active_Bios), .Next_Bios_latch(Next_Bios_latch),
        .BIOS_CS_N(BIOS_CS_N), .Boot_Ok(Boot_Ok), .Bios_Fail(Bios_Fail),
        .Rst_Req(Rst_Req), .Retry_Cnt(Retry_Cnt)
    );

    bios_failover_ctrl #(
        .NUM_BIOS(3), .SEL_W(2), .BOOT_TIMEOUT(16'd8), .TMR_W(16),
        .MAX_RETRY(2), .RST_PULSE(4)
    ) dut3 (
        .Clk(Clk), .Reset(Reset), .PciRstN(PciRstN), .Pwr_ok(Pwr_ok),
        .Post_Done(Post_Done), .Tick(Tick), .Next_Bios(next3),
        .Active_Bios(active3), .Next_Bios_latch(latch3),
        .BIOS_CS_N(cs3), .Boot_Ok(boot_ok3), .Bios_Fail(fail3),
        .Rst_Req(rst_req3), .Retry_Cnt(retry3)
    );

    // model: out-of-range requests fall back to BIOS 0
    function automatic int model_clamp(input int v, input int n);
        return (v < n) ? v : 0;
    endfunction

    // model: failover goes to the following socket, wrapping
    function automatic int model_next(input int a, input int n);
        return (a + 1) % n;
    endfunction

    // model: one-cold select, all ones when powered off
    function automatic logic [2:0] model_cs(input int a, input int n, input bit off);
        logic [2:0] v;
        v = 3'b111;
        if (!off) v[a] = 1'b0;
        if (n == 2) v[2] = 1'b0;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // each tick preceded by a random gap, so the last tick ends on a sample point
    task automatic give_ticks(input int n);
        repeat (n) begin
            step($urandom_range(0, 3));
            Tick = 1'b1;
            step(1);
            Tick = 1'b0;
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Pwr_ok = 1'b0; PciRstN = 1'b0; Post_Done = 1'b0;
        Tick = 1'b0; Next_Bios = 1'b0; next3 = 2'd0;
        step(3);
        n_total++;
        if (Active_Bios !== 1'b0) $display("FAIL rst_active got %0d want 0", Active_Bios); else n_pass++;
        n_total++;
        if (Next_Bios_latch !== 1'b0) $display("FAIL rst_latch got %0d want 0", Next_Bios_latch); else n_pass++;
        n_total++;
        if (BIOS_CS_N !== 2'b11) $display("FAIL rst_cs got %b want 11", BIOS_CS_N); else n_pass++;
        n_total++;
        if ({Boot_Ok, Bios_Fail, Rst_Req} !== 3'b000)
            $display("FAIL rst_flags got %b want 000", {Boot_Ok, Bios_Fail, Rst_Req}); else n_pass++;
        n_total++;
        if (Retry_Cnt !== 3'd0) $display("FAIL rst_retry got %0d want 0", Retry_Cnt); else n_pass++;
        m_active = 0; m_retry = 0; m_latch = 0;
    endtask

    task automatic test_select;
        logic [2:0] exp_cs;
        Reset = 1'b0; Pwr_ok = 1'b1; PciRstN = 1'b0; Next_Bios = 1'b1;
        step(5);
        m_latch = model_clamp(1, 2);
        n_total++;
        if (int'(Next_Bios_latch) != m_latch) $display("FAIL sel_latch got %0d want %0d", Next_Bios_latch, m_latch); else n_pass++;
        PciRstN = 1'b1;
        step(3);
        m_active = m_latch;
        exp_cs = model_cs(m_active, 2, 1'b0);
        n_total++;
        if (int'(Active_Bios) != m_active) $display("FAIL sel_active got %0d want %0d", Active_Bios, m_active); else n_pass++;
        n_total++;
        if (BIOS_CS_N !== exp_cs[1:0]) $display("FAIL sel_cs got %b want %b", BIOS_CS_N, exp_cs[1:0]); else n_pass++;
    endtask

    task automatic test_post_done;
        bit seen_req;
        int k;
        k = $urandom_range(1, 7);
        give_ticks(k);
        Post_Done = 1'b1;
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (Rst_Req) seen_req = 1'b1;
        end
        n_total++;
        if (Boot_Ok !== 1'b1) $display("FAIL post_bootok got %b want 1 (ticks %0d)", Boot_Ok, k); else n_pass++;
        n_total++;
        if (seen_req !== 1'b0) $display("FAIL post_noreq got %b want 0", seen_req); else n_pass++;
        n_total++;
        if (int'(Retry_Cnt) != m_retry) $display("FAIL post_retry got %0d want %0d", Retry_Cnt, m_retry); else n_pass++;
        // warm reset back to BIOS 0
        Post_Done = 1'b0; PciRstN = 1'b0; Next_Bios = 1'b0;
        step(5);
        m_latch = 0;
        n_total++;
        if (Boot_Ok !== 1'b0) $display("FAIL warm_bootok got %b want 0", Boot_Ok); else n_pass++;
        n_total++;
        if (int'(Next_Bios_latch) != m_latch) $display("FAIL warm_latch got %0d want %0d", Next_Bios_latch, m_latch); else n_pass++;
        PciRstN = 1'b1;
        step(3);
        m_active = m_latch;
        n_total++;
        if (int'(Active_Bios) != m_active) $display("FAIL warm_active got %0d want %0d", Active_Bios, m_active); else n_pass++;
    endtask

    task automatic test_timeout;
        int high;
        bit moved;
        logic [2:0] exp_cs;
        give_ticks(8);
        high = 0; moved = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (Rst_Req) begin
                high++;
                if (int'(Active_Bios) != m_active) moved = 1'b1;
            end
        end
        m_retry++;
        m_latch = model_next(m_active, 2);
        n_total++;
        if (high != 4) $display("FAIL tmo_pulse_len got %0d want 4", high); else n_pass++;
        n_total++;
        if (moved !== 1'b0) $display("FAIL tmo_active_held got changed want held"); else n_pass++;
        n_total++;
        if (int'(Retry_Cnt) != m_retry) $display("FAIL tmo_retry got %0d want %0d", Retry_Cnt, m_retry); else n_pass++;
        PciRstN = 1'b0; Next_Bios = 1'b0;
        step(5);
        n_total++;
        if (int'(Next_Bios_latch) != m_latch) $display("FAIL tmo_latch_hold got %0d want %0d", Next_Bios_latch, m_latch); else n_pass++;
        PciRstN = 1'b1;
        step(3);
        m_active = m_latch;
        exp_cs = model_cs(m_active, 2, 1'b0);
        n_total++;
        if (int'(Active_Bios) != m_active) $display("FAIL tmo_active got %0d want %0d", Active_Bios, m_active); else n_pass++;
        n_total++;
        if (BIOS_CS_N !== exp_cs[1:0]) $display("FAIL tmo_cs got %b want %b", BIOS_CS_N, exp_cs[1:0]); else n_pass++;
    endtask

    task automatic test_exhaust;
        int high;
        bit done;
        logic [2:0] exp_cs;
        done = 1'b0;
        for (int attempt = 0; attempt < 3 && !done; attempt++) begin
            give_ticks(8);
            if (m_retry < 2) begin
                high = 0;
                for (int i = 0; i < 12; i++) begin
                    step(1);
                    if (Rst_Req) high++;
                end
                m_retry++;
                m_active = model_next(m_active, 2);
                n_total++;
                if (high != 4) $display("FAIL exh_pulse_len got %0d want 4", high); else n_pass++;
                n_total++;
                if (int'(Retry_Cnt) != m_retry) $display("FAIL exh_retry got %0d want %0d", Retry_Cnt, m_retry); else n_pass++;
                PciRstN = 1'b0; Next_Bios = 1'($urandom_range(0, 1));
                step(5);
                PciRstN = 1'b1;
                step(3);
                n_total++;
                if (int'(Active_Bios) != m_active) $display("FAIL exh_active got %0d want %0d", Active_Bios, m_active); else n_pass++;
            end else begin
                step(3);
                done = 1'b1;
                n_total++;
                if (Bios_Fail !== 1'b1) $display("FAIL exh_fail got %b want 1", Bios_Fail); else n_pass++;
            end
        end
        n_total++;
        if (!done) $display("FAIL exh_reached got no failure want failure"); else n_pass++;
        // FAILED ignores platform resets
        for (int i = 0; i < 3; i++) begin
            PciRstN = 1'b0; Next_Bios = 1'($urandom_range(0, 1));
            step($urandom_range(3, 6));
            PciRstN = 1'b1;
            step($urandom_range(3, 6));
        end
        exp_cs = model_cs(m_active, 2, 1'b0);
        n_total++;
        if (Bios_Fail !== 1'b1) $display("FAIL fail_sticky got %b want 1", Bios_Fail); else n_pass++;
        n_total++;
        if (int'(Active_Bios) != m_active) $display("FAIL fail_active got %0d want %0d", Active_Bios, m_active); else n_pass++;
        n_total++;
        if (Rst_Req !== 1'b0) $display("FAIL fail_rstreq got %b want 0", Rst_Req); else n_pass++;
        n_total++;
        if (int'(Retry_Cnt) != m_retry) $display("FAIL fail_retry got %0d want %0d", Retry_Cnt, m_retry); else n_pass++;
        n_total++;
        if (BIOS_CS_N !== exp_cs[1:0]) $display("FAIL fail_cs got %b want %b", BIOS_CS_N, exp_cs[1:0]); else n_pass++;
    endtask

    task automatic test_pwr_loss;
        // from FAILED
        Pwr_ok = 1'b0;
        step(3);
        m_active = 0; m_retry = 0;
        n_total++;
        if (BIOS_CS_N !== 2'b11) $display("FAIL pwr_fail_cs got %b want 11", BIOS_CS_N); else n_pass++;
        n_total++;
        if (int'(Active_Bios) != m_active) $display("FAIL pwr_fail_active got %0d want 0", Active_Bios); else n_pass++;
        n_total++;
        if (int'(Retry_Cnt) != m_retry) $display("FAIL pwr_fail_retry got %0d want 0", Retry_Cnt); else n_pass++;
        n_total++;
        if (Bios_Fail !== 1'b0) $display("FAIL pwr_fail_flag got %b want 0", Bios_Fail); else n_pass++;
        // from BOOTING on BIOS 1
        PciRstN = 1'b0; Next_Bios = 1'b1; Pwr_ok = 1'b1;
        step(5);
        PciRstN = 1'b1;
        step(3);
        n_total++;
        if (Active_Bios !== 1'b1) $display("FAIL pwr_boot_active got %0d want 1", Active_Bios); else n_pass++;
        give_ticks($urandom_range(1, 5));
        Pwr_ok = 1'b0;
        step(3);
        n_total++;
        if (BIOS_CS_N !== 2'b11) $display("FAIL pwr_boot_cs got %b want 11", BIOS_CS_N); else n_pass++;
        n_total++;
        if (Active_Bios !== 1'b0) $display("FAIL pwr_boot_active0 got %0d want 0", Active_Bios); else n_pass++;
    endtask

    task automatic test_reset_mid_req;
        bit seen;
        logic [2:0] exp_cs;
        // PciRstN already high on power-up counts as the release
        PciRstN = 1'b1; Pwr_ok = 1'b1;
        step(5);
        exp_cs = model_cs(0, 2, 1'b0);
        n_total++;
        if (BIOS_CS_N !== exp_cs[1:0]) $display("FAIL pwrup_cs got %b want %b", BIOS_CS_N, exp_cs[1:0]); else n_pass++;
        give_ticks(8);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            step(1);
            if (Rst_Req) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL midreq_seen got 0 want 1"); else n_pass++;
        step(1);
        Reset = 1'b1;
        #1;
        n_total++;
        if (Rst_Req !== 1'b0) $display("FAIL midreq_rstreq got %b want 0", Rst_Req); else n_pass++;
        step(1);
        Reset = 1'b0;
    endtask

    task automatic test_same_cycle;
        bit seen;
        PciRstN = 1'b0; Next_Bios = 1'($urandom_range(0, 1)); Pwr_ok = 1'b1;
        step(5);
        PciRstN = 1'b1;
        step(3);
        give_ticks(7);
        // Post_Done lands in the synchroniser output the same cycle the
        // watchdog reaches its limit
        Post_Done = 1'b1;
        step(1);
        Tick = 1'b1;
        step(1);
        Tick = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (Rst_Req) seen = 1'b1;
        end
        n_total++;
        if (Boot_Ok !== 1'b1) $display("FAIL tie_bootok got %b want 1", Boot_Ok); else n_pass++;
        n_total++;
        if (seen) $display("FAIL tie_noreq got 1 want 0"); else n_pass++;
        n_total++;
        if (Retry_Cnt !== 3'd0) $display("FAIL tie_retry got %0d want 0", Retry_Cnt); else n_pass++;
        Post_Done = 1'b0;
    endtask

    task automatic test_clamp_wrap;
        int a3, l3;
        logic [2:0] exp_cs;
        Reset = 1'b1; Pwr_ok = 1'b0; PciRstN = 1'b0;
        step(2);
        Reset = 1'b0; Pwr_ok = 1'b1; next3 = 2'd3;
        step(5);
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin
                next3 = 2'($urandom_range(0, 3));
                step(2);
            end
            l3 = model_clamp(int'(next3), 3);
            n_total++;
            if (int'(latch3) != l3) $display("FAIL clamp_latch req %0d got %0d want %0d", next3, latch3, l3); else n_pass++;
        end
        next3 = 2'd2;
        step(2);
        PciRstN = 1'b1;
        step(3);
        a3 = 2;
        n_total++;
        if (int'(active3) != a3) $display("FAIL wrap_active got %0d want %0d", active3, a3); else n_pass++;
        give_ticks(8);
        step(8);
        l3 = model_next(a3, 3);
        n_total++;
        if (int'(latch3) != l3) $display("FAIL wrap_latch got %0d want %0d", latch3, l3); else n_pass++;
        n_total++;
        if (retry3 !== 3'd1) $display("FAIL wrap_retry got %0d want 1", retry3); else n_pass++;
        PciRstN = 1'b0;
        step(5);
        PciRstN = 1'b1;
        step(3);
        a3 = l3;
        exp_cs = model_cs(a3, 3, 1'b0);
        n_total++;
        if (int'(active3) != a3) $display("FAIL wrap_active2 got %0d want %0d", active3, a3); else n_pass++;
        n_total++;
        if (cs3 !== exp_cs) $display("FAIL wrap_cs got %b want %b", cs3, exp_cs); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_select();
        test_post_done();
        test_timeout();
        test_exhaust();
        test_pwr_loss();
        test_reset_mid_req();
        test_same_cycle();
        test_clamp_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
